// File: rtl/axi_slave_mem.sv
// SAXI memory responder: queued writes with in-order B responses, and reads
// returned out of order from a small pool of latency-timed slots.
module axi_slave_mem #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int ID_W       = 4,
    parameter int MEM_AW     = 6,
    parameter int READ_SLOTS = 4,
    parameter int RD_LAT     = 1,
    parameter int LAT_SEL    = 8,
    parameter int WQ_DEPTH   = 2,
    parameter int B_MAX      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] araddr,
    input  logic [ID_W-1:0]   arid,
    input  logic              arvalid,
    output logic              arready,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic              awvalid,
    output logic              awready,
    input  logic [DATA_W-1:0] wdata,
    input  logic              wvalid,
    output logic              wready,
    output logic [DATA_W-1:0] rdata,
    output logic [ID_W-1:0]   rid,
    output logic              rvalid,
    input  logic              rready,
    output logic              bvalid,
    input  logic              bready
);
    localparam int QP_W  = (WQ_DEPTH > 1) ? $clog2(WQ_DEPTH) : 1;
    localparam int QC_W  = $clog2(WQ_DEPTH + 1);
    localparam int BC_W  = $clog2(B_MAX + 1);
    localparam int CNT_W = $clog2(RD_LAT + 4);
    localparam int SI_W  = (READ_SLOTS > 1) ? $clog2(READ_SLOTS) : 1;

    logic [MEM_AW-1:0] awq_q [WQ_DEPTH];
    logic [DATA_W-1:0] wq_q  [WQ_DEPTH];
    logic [DATA_W-1:0] mem_q [2**MEM_AW];

    logic [QP_W-1:0] aw_wp_q, aw_wp_d, aw_rp_q, aw_rp_d;
    logic [QP_W-1:0] w_wp_q, w_wp_d, w_rp_q, w_rp_d;
    logic [QC_W-1:0] aw_cnt_q, aw_cnt_d, w_cnt_q, w_cnt_d;
    logic [BC_W-1:0] bcnt_q, bcnt_d;
    logic            live_q;

    logic [READ_SLOTS-1:0] slot_v_q, slot_v_d;
    logic [ID_W-1:0]       slot_id_q   [READ_SLOTS];
    logic [ID_W-1:0]       slot_id_d   [READ_SLOTS];
    logic [DATA_W-1:0]     slot_data_q [READ_SLOTS];
    logic [DATA_W-1:0]     slot_data_d [READ_SLOTS];
    logic [CNT_W-1:0]      slot_cnt_q  [READ_SLOTS];
    logic [CNT_W-1:0]      slot_cnt_d  [READ_SLOTS];

    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [ID_W-1:0]   rid_q, rid_d;
    logic              rvalid_q, rvalid_d;

    logic            aw_push, w_push, commit, b_hs, ar_acc, r_load;
    logic            free_found, elig_found;
    logic [SI_W-1:0] free_idx, elig_idx;
    logic            unused_addr_bits;

    function automatic logic [QP_W-1:0] qp_inc(input logic [QP_W-1:0] p);
        return (p == QP_W'(WQ_DEPTH - 1)) ? '0 : p + QP_W'(1);
    endfunction

    assign unused_addr_bits = ^{araddr, awaddr};

    assign commit  = !rst && (aw_cnt_q != '0) && (w_cnt_q != '0) && (bcnt_q < BC_W'(B_MAX));
    // A commit pops both queues, so a full queue can still take a push at that edge.
    assign awready = live_q && !rst && ((aw_cnt_q != QC_W'(WQ_DEPTH)) || commit);
    assign wready  = live_q && !rst && ((w_cnt_q != QC_W'(WQ_DEPTH)) || commit);
    assign aw_push = awvalid && awready;
    assign w_push  = wvalid && wready;
    assign bvalid  = (bcnt_q != '0);
    assign b_hs    = bvalid && bready;

    assign arready = live_q && !rst && free_found;
    assign ar_acc  = arvalid && arready;
    assign r_load  = (!rvalid_q || rready) && elig_found;
    assign rvalid  = rvalid_q;
    assign rdata   = rdata_q;
    assign rid     = rid_q;

    always_comb begin : slot_search
        free_found = 1'b0;
        free_idx   = '0;
        elig_found = 1'b0;
        elig_idx   = '0;
        for (int i = READ_SLOTS - 1; i >= 0; i--) begin
            if (!slot_v_q[i]) begin
                free_found = 1'b1;
                free_idx   = SI_W'(i);
            end
            if (slot_v_q[i] && (slot_cnt_q[i] == '0)) begin
                elig_found = 1'b1;
                elig_idx   = SI_W'(i);
            end
        end
    end

    always_comb begin : next_state
        aw_wp_d  = aw_push ? qp_inc(aw_wp_q) : aw_wp_q;
        aw_rp_d  = commit  ? qp_inc(aw_rp_q) : aw_rp_q;
        w_wp_d   = w_push  ? qp_inc(w_wp_q)  : w_wp_q;
        w_rp_d   = commit  ? qp_inc(w_rp_q)  : w_rp_q;
        aw_cnt_d = aw_cnt_q + QC_W'(aw_push) - QC_W'(commit);
        w_cnt_d  = w_cnt_q + QC_W'(w_push) - QC_W'(commit);
        bcnt_d   = bcnt_q + BC_W'(commit) - BC_W'(b_hs);

        slot_v_d    = slot_v_q;
        slot_id_d   = slot_id_q;
        slot_data_d = slot_data_q;
        for (int i = 0; i < READ_SLOTS; i++) begin
            slot_cnt_d[i] = (slot_v_q[i] && (slot_cnt_q[i] != '0)) ?
                            slot_cnt_q[i] - CNT_W'(1) : slot_cnt_q[i];
        end
        if (r_load) slot_v_d[elig_idx] = 1'b0;
        // Data is sampled before this edge's commit lands, giving read-before-write.
        if (ar_acc) begin
            slot_v_d[free_idx]    = 1'b1;
            slot_id_d[free_idx]   = arid;
            slot_data_d[free_idx] = mem_q[araddr[MEM_AW+1:2]];
            slot_cnt_d[free_idx]  = CNT_W'(RD_LAT) + CNT_W'(araddr[LAT_SEL+1:LAT_SEL]);
        end

        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rid_d    = rid_q;
        if (r_load) begin
            rvalid_d = 1'b1;
            rdata_d  = slot_data_q[elig_idx];
            rid_d    = slot_id_q[elig_idx];
        end else if (rready) begin
            rvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            live_q   <= 1'b0;
            aw_wp_q  <= '0;
            aw_rp_q  <= '0;
            w_wp_q   <= '0;
            w_rp_q   <= '0;
            aw_cnt_q <= '0;
            w_cnt_q  <= '0;
            bcnt_q   <= '0;
            slot_v_q <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rid_q    <= '0;
            for (int i = 0; i < READ_SLOTS; i++) begin
                slot_id_q[i]   <= '0;
                slot_data_q[i] <= '0;
                slot_cnt_q[i]  <= '0;
            end
        end else begin
            live_q      <= 1'b1;
            aw_wp_q     <= aw_wp_d;
            aw_rp_q     <= aw_rp_d;
            w_wp_q      <= w_wp_d;
            w_rp_q      <= w_rp_d;
            aw_cnt_q    <= aw_cnt_d;
            w_cnt_q     <= w_cnt_d;
            bcnt_q      <= bcnt_d;
            slot_v_q    <= slot_v_d;
            slot_id_q   <= slot_id_d;
            slot_data_q <= slot_data_d;
            slot_cnt_q  <= slot_cnt_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
            rid_q       <= rid_d;
        end
    end

    // Queue entries and memory words are plain storage; only pointers and counts reset.
    always_ff @(posedge clk) begin
        if (aw_push) awq_q[aw_wp_q] <= awaddr[MEM_AW+1:2];
        if (w_push)  wq_q[w_wp_q]   <= wdata;
        if (commit)  mem_q[awq_q[aw_rp_q]] <= wq_q[w_rp_q];
    end
endmodule
